// File: rtl/sma_share_arbiter_if.sv
// Handshake bundle for sma_share_arbiter: per-requester operand offers and the
// tagged sign-magnitude sum response channel.
interface sma_share_arbiter_if #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned NUM_REQ    = 4
);
   localparam int unsigned ID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ-1:0]            req_ready;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_a;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_b;
   logic                          rsp_valid;
   logic                          rsp_ready;
   logic [DATA_WIDTH:0]           rsp_sum;
   logic [ID_W-1:0]               rsp_id;

   // Requester/consumer side.
   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_sum, rsp_id
   );

   // Arbiter side.
   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_sum, rsp_id
   );
endinterface

// File: rtl/sma_share_arbiter.sv
// Shares one two-stage sign-magnitude adder among NUM_REQ requesters.
// SMA_SHARE_RR_EN defined: round-robin grant; undefined: fixed lowest-index priority.
module sma_share_arbiter #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned NUM_REQ    = 4
) (
   input logic                clk,
   input logic                rst_n,
   sma_share_arbiter_if.slave bus
);
   localparam int unsigned ID_W  = $clog2(NUM_REQ);
   localparam int unsigned MAG_W = DATA_WIDTH - 1;

   logic                  s1_valid;
   logic [DATA_WIDTH-1:0] s1_a;
   logic [DATA_WIDTH-1:0] s1_b;
   logic [ID_W-1:0]       s1_id;

   logic                  s2_adv;
   logic                  s1_adv;

   logic                  grant_found;
   logic [ID_W-1:0]       grant_id;
   logic [NUM_REQ-1:0]    grant_vec;
   logic                  accept;

   logic                  sa;
   logic                  sb;
   logic [DATA_WIDTH-1:0] ma;
   logic [DATA_WIDTH-1:0] mb;
   logic [DATA_WIDTH-1:0] sum_mag;
   logic                  sum_sign;
   logic [DATA_WIDTH:0]   sum_next;

   assign s2_adv = !bus.rsp_valid || bus.rsp_ready;
   assign s1_adv = !s1_valid || s2_adv;

`ifdef SMA_SHARE_RR_EN
   logic [ID_W-1:0] rr_ptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= '0;
      end else if (accept) begin
         rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
      end
   end
`endif

   // First valid requester in search order; search starts at rr_ptr when round-robin.
   always_comb begin
      int unsigned pos;
      grant_found = 1'b0;
      grant_id    = '0;
      pos         = 0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
`ifdef SMA_SHARE_RR_EN
         pos = 32'(rr_ptr) + k;
         if (pos >= NUM_REQ) pos = pos - NUM_REQ;
`else
         pos = k;
`endif
         if (!grant_found && bus.req_valid[ID_W'(pos)]) begin
            grant_found = 1'b1;
            grant_id    = ID_W'(pos);
         end
      end
   end

   assign grant_vec     = (rst_n && s1_adv && grant_found) ? (NUM_REQ'(1) << grant_id) : '0;
   assign accept        = |grant_vec;
   assign bus.req_ready = grant_vec;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_id    <= '0;
      end else if (s1_adv) begin
         s1_valid <= accept;
         if (accept) begin
            s1_a  <= bus.req_a[grant_id*DATA_WIDTH +: DATA_WIDTH];
            s1_b  <= bus.req_b[grant_id*DATA_WIDTH +: DATA_WIDTH];
            s1_id <= grant_id;
         end
      end
   end

   assign sa = s1_a[DATA_WIDTH-1];
   assign sb = s1_b[DATA_WIDTH-1];
   assign ma = {1'b0, s1_a[MAG_W-1:0]};
   assign mb = {1'b0, s1_b[MAG_W-1:0]};

   // Magnitudes are zero-extended by one bit, so the same-sign sum cannot overflow.
   always_comb begin
      sum_mag  = '0;
      sum_sign = 1'b0;
      if (sa == sb) begin
         sum_mag  = ma + mb;
         sum_sign = sa;
      end else if (ma > mb) begin
         sum_mag  = ma - mb;
         sum_sign = sa;
      end else if (mb > ma) begin
         sum_mag  = mb - ma;
         sum_sign = sb;
      end
      sum_next = {sum_sign & (|sum_mag), sum_mag};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.rsp_valid <= 1'b0;
         bus.rsp_sum   <= '0;
         bus.rsp_id    <= '0;
      end else if (s2_adv) begin
         bus.rsp_valid <= s1_valid;
         if (s1_valid) begin
            bus.rsp_sum <= sum_next;
            bus.rsp_id  <= s1_id;
         end
      end
   end
endmodule

// File: tb/tb_sma_share_arbiter.sv
// Directed self-checking bench for sma_share_arbiter (DATA_WIDTH=8, NUM_REQ=4).
module tb_sma_share_arbiter;
   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   sma_share_arbiter_if #(.DATA_WIDTH(8), .NUM_REQ(4)) bus ();

   sma_share_arbiter #(.DATA_WIDTH(8), .NUM_REQ(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      bus.req_valid = '0;
      bus.rsp_ready = 1'b1;
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic apply_reset();
      bus.req_valid = '0;
      rst_n = 1'b0;
      #2;
      @(negedge clk);
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_reset();
      bus.req_valid = 4'b0001;
      bus.req_a     = 32'h0000_0001;
      bus.req_b     = 32'h0000_0002;
      bus.rsp_ready = 1'b1;
      rst_n = 1'b0;
      #3;
      total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
      total++; if (bus.rsp_sum !== 9'h000) begin bad++; $display("FAIL reset_rsp_sum: got %h want 000", bus.rsp_sum); end
      total++; if (bus.rsp_id !== 2'd0) begin bad++; $display("FAIL reset_rsp_id: got %0d want 0", bus.rsp_id); end
      total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL reset_req_ready: got %b want 0000", bus.req_ready); end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL reset_first_accept: got %b want 0001", bus.req_ready); end
      step();
      bus.req_valid = '0;
      step();
      total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_sum !== 9'h003) begin
         bad++; $display("FAIL reset_first_rsp: got v=%b sum=%h want v=1 sum=003", bus.rsp_valid, bus.rsp_sum);
      end
      idle(2);
   endtask

   task automatic test_arith();
      logic [7:0] ta [6];
      logic [7:0] tb_v [6];
      logic [8:0] ts [6];
      ta   = '{8'h05, 8'h85, 8'h7F, 8'h03, 8'h83, 8'h80};
      tb_v = '{8'h03, 8'h03, 8'h7F, 8'h86, 8'h03, 8'h80};
      ts   = '{9'h008, 9'h102, 9'h0FE, 9'h103, 9'h000, 9'h000};
      bus.rsp_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         bus.req_a     = {24'h0, ta[i]};
         bus.req_b     = {24'h0, tb_v[i]};
         bus.req_valid = 4'b0001;
         #1;
         total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL arith_ready[%0d]: got %b want 0001", i, bus.req_ready); end
         step();
         bus.req_valid = '0;
         #1;
         total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL arith_early[%0d]: got rsp_valid %b want 0", i, bus.rsp_valid); end
         step();
         total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL arith_valid[%0d]: got %b want 1", i, bus.rsp_valid); end
         total++; if (bus.rsp_sum !== ts[i]) begin bad++; $display("FAIL arith_sum[%0d]: got %h want %h", i, bus.rsp_sum, ts[i]); end
         total++; if (bus.rsp_id !== 2'd0) begin bad++; $display("FAIL arith_id[%0d]: got %0d want 0", i, bus.rsp_id); end
         step();
      end
      idle(1);
   endtask

   task automatic test_arbitration();
      int exp_seq [6];
`ifdef SMA_SHARE_RR_EN
      exp_seq = '{0, 1, 2, 3, 0, 1};
`else
      exp_seq = '{0, 0, 0, 0, 0, 0};
`endif
      apply_reset();
      bus.req_a     = {8'h04, 8'h03, 8'h02, 8'h01};
      bus.req_b     = {8'h10, 8'h10, 8'h10, 8'h10};
      bus.rsp_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         bus.req_valid = (c < 6) ? 4'hF : 4'h0;
         #1;
         if (c < 6) begin
            total++; if (bus.req_ready !== (4'(1) << exp_seq[c])) begin
               bad++; $display("FAIL arb_grant[%0d]: got %b want %b", c, bus.req_ready, 4'(1) << exp_seq[c]);
            end
         end
         if (c >= 2) begin
            total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'(exp_seq[c-2]) || bus.rsp_sum !== 9'(exp_seq[c-2] + 17)) begin
               bad++; $display("FAIL arb_rsp[%0d]: got v=%b id=%0d sum=%h want v=1 id=%0d sum=%h",
                               c, bus.rsp_valid, bus.rsp_id, bus.rsp_sum, exp_seq[c-2], 9'(exp_seq[c-2] + 17));
            end
         end
         step();
      end
      total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL arb_drained: got rsp_valid %b want 0", bus.rsp_valid); end
      idle(1);
   endtask

   task automatic test_backpressure();
      int acc;
      int idx;
      int got;
      acc = 0;
      idx = 0;
      got = 0;
      bus.req_b     = {16'h0, 8'h01, 8'h00};
      bus.rsp_ready = 1'b0;
      for (int c = 0; c < 6; c++) begin
         bus.req_valid = (idx < 5) ? 4'b0010 : 4'b0000;
         bus.req_a     = {16'h0, 8'(idx + 2), 8'h00};
         #1;
         total++; if (bus.req_ready !== ((acc < 2) ? 4'b0010 : 4'b0000)) begin
            bad++; $display("FAIL bp_ready[%0d]: got %b want %b", c, bus.req_ready, (acc < 2) ? 4'b0010 : 4'b0000);
         end
         total++; if (bus.rsp_valid !== (c >= 2)) begin bad++; $display("FAIL bp_valid[%0d]: got %b want %b", c, bus.rsp_valid, c >= 2); end
         if (c >= 2) begin
            total++; if (bus.rsp_sum !== 9'h003 || bus.rsp_id !== 2'd1) begin
               bad++; $display("FAIL bp_stable[%0d]: got sum=%h id=%0d want sum=003 id=1", c, bus.rsp_sum, bus.rsp_id);
            end
         end
         if (bus.req_ready[1]) begin acc++; idx++; end
         step();
      end
      total++; if (acc != 2) begin bad++; $display("FAIL bp_accepts: got %0d want 2", acc); end
      bus.rsp_ready = 1'b1;
      for (int c = 0; c < 20; c++) begin
         if (got >= 5) break;
         bus.req_valid = (idx < 5) ? 4'b0010 : 4'b0000;
         bus.req_a     = {16'h0, 8'(idx + 2), 8'h00};
         #1;
         if (bus.rsp_valid) begin
            total++; if (bus.rsp_sum !== 9'(got + 3) || bus.rsp_id !== 2'd1) begin
               bad++; $display("FAIL bp_order[%0d]: got sum=%h id=%0d want sum=%h id=1", got, bus.rsp_sum, bus.rsp_id, 9'(got + 3));
            end
            got++;
         end
         if (bus.req_ready[1]) idx++;
         step();
      end
      total++; if (got != 5) begin bad++; $display("FAIL bp_count: got %0d results want 5", got); end
      total++; if (idx != 5) begin bad++; $display("FAIL bp_accepted: got %0d want 5", idx); end
      bus.req_valid = '0;
      #1;
      total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_no_dup: got rsp_valid %b want 0", bus.rsp_valid); end
      idle(2);
   endtask

   task automatic test_reset_mid();
      bus.rsp_ready = 1'b0;
      bus.req_valid = 4'b0100;
      bus.req_a     = {8'h00, 8'h11, 16'h0};
      bus.req_b     = {8'h00, 8'h01, 16'h0};
      step();
      step();
      total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL rst_mid_full: got rsp_valid %b want 1", bus.rsp_valid); end
      #3;
      rst_n = 1'b0;
      #1;
      total++; if (bus.rsp_valid !== 1'b0 || bus.rsp_sum !== 9'h000) begin
         bad++; $display("FAIL rst_mid_async: got v=%b sum=%h want v=0 sum=000", bus.rsp_valid, bus.rsp_sum);
      end
      total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL rst_mid_ready: got %b want 0000", bus.req_ready); end
      bus.req_valid = '0;
      #2;
      rst_n = 1'b1;
      bus.rsp_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         step();
         total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_stale[%0d]: got rsp_valid %b want 0", c, bus.rsp_valid); end
      end
      bus.req_valid = 4'hF;
      #1;
      total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL rst_mid_ptr: got %b want 0001", bus.req_ready); end
      step();
      idle(3);
   endtask

   initial begin
      total         = 0;
      bad           = 0;
      rst_n         = 1'b0;
      bus.req_valid = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.rsp_ready = 1'b0;
      test_reset();
      test_arith();
      test_arbitration();
      test_backpressure();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
